// File: rtl/free_list_pkg.sv
// Shared rename-stage types: physical tag width, free-list pointer and
// the branch checkpoint image that captures the free-list head.
package free_list_pkg;

  localparam int N                 = 3;
  localparam int PHYS_REGS         = 64;
  localparam int ARCH_REGS         = 32;
  localparam int DEPTH             = PHYS_REGS - ARCH_REGS;
  localparam int PTR_BITS          = $clog2(DEPTH);
  localparam int PHYS_REG_IDX_BITS = $clog2(PHYS_REGS);
  localparam int NUM_SCALAR_BITS   = $clog2(N + 1);

  typedef logic [PHYS_REG_IDX_BITS-1:0] PHYS_REG_IDX;
  // One extra wrap bit so that full and empty are distinguishable.
  typedef logic [PTR_BITS:0]            FREE_LIST_PTR;
  typedef logic [NUM_SCALAR_BITS-1:0]   NUM_SCALAR;

  // State saved at a branch so a mispredict can rewind rename.
  typedef struct packed {
    logic         valid;
    FREE_LIST_PTR free_list_head;
  } BRANCH_CHECKPOINT;

  // Smaller of two lane counts.
  function automatic NUM_SCALAR min_scalar(input NUM_SCALAR a, input NUM_SCALAR b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register tags for R10K-style rename.
// Dispatch consumes tags from head, retire returns T_old tags at tail,
// and a branch mispredict rewinds head to a checkpointed value.
module free_list
  import free_list_pkg::*;
(
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_SCALAR_BITS-1:0]             num_allocating,
  output logic [N-1:0][PHYS_REG_IDX_BITS-1:0]    allocated_regs,
  output logic [NUM_SCALAR_BITS-1:0]             num_avail,
  input  logic [N-1:0][PHYS_REG_IDX_BITS-1:0]    inputs_retiring,
  input  logic [NUM_SCALAR_BITS-1:0]             num_retiring_valid,
  output logic [PTR_BITS:0]                      head_out,
  input  logic                                   restore_valid,
  input  logic [PTR_BITS:0]                      restore_head,
  output logic [PTR_BITS:0]                      free_count
);

  PHYS_REG_IDX  entries_reg [DEPTH];
  FREE_LIST_PTR head_reg;
  FREE_LIST_PTR tail_reg;
  FREE_LIST_PTR head_next;
  FREE_LIST_PTR tail_next;
  FREE_LIST_PTR count;
  NUM_SCALAR    alloc_grant;

  logic [PTR_BITS-1:0] write_idx [N];
  logic [N-1:0]        write_en;

  // Occupancy relies on modular subtraction of the wrap-extended pointers.
  assign count      = tail_reg - head_reg;
  assign free_count = count;
  assign head_out   = head_reg;
  assign num_avail  = (count >= FREE_LIST_PTR'(N)) ? NUM_SCALAR'(N)
                                                   : count[NUM_SCALAR_BITS-1:0];

  // Read and write lane addressing, wrapping modulo DEPTH.
  for (genvar gi = 0; gi < N; gi++) begin : g_lanes
    assign allocated_regs[gi] =
      entries_reg[PTR_BITS'(head_reg[PTR_BITS-1:0] + PTR_BITS'(gi))];
    assign write_idx[gi] = PTR_BITS'(tail_reg[PTR_BITS-1:0] + PTR_BITS'(gi));
    assign write_en[gi]  = (NUM_SCALAR'(gi) < num_retiring_valid);
  end

  // Pointer update: restore wins over allocate; over-allocation is clamped.
  always_comb begin
    alloc_grant = '0;
    if (!restore_valid) begin
      alloc_grant = min_scalar(num_allocating, num_avail);
    end
    head_next = restore_valid ? FREE_LIST_PTR'(restore_head)
                              : head_reg + FREE_LIST_PTR'(alloc_grant);
    tail_next = tail_reg + FREE_LIST_PTR'(num_retiring_valid);
  end

  // Head/tail registers; reset leaves the list full with tags ARCH_REGS and up.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg <= '0;
      tail_reg <= {1'b1, {PTR_BITS{1'b0}}};
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  // Tag storage: reset image plus packed retire-lane writes at tail.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i] <= PHYS_REG_IDX'(ARCH_REGS + i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (write_en[i]) begin
          entries_reg[write_idx[i]] <= inputs_retiring[i];
        end
      end
    end
  end

  // Simulation-only guards on the dispatch and retire contracts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (restore_valid || (num_allocating <= num_avail));
      assert ((int'(count) + int'(num_retiring_valid)) <= DEPTH);
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed vectors with literal expectations plus a
// queue-level reference model compared against the outputs every cycle.
module tb_free_list;
  import free_list_pkg::*;

  logic                                clock;
  logic                                reset;
  logic [NUM_SCALAR_BITS-1:0]          num_allocating;
  logic [N-1:0][PHYS_REG_IDX_BITS-1:0] allocated_regs;
  logic [NUM_SCALAR_BITS-1:0]          num_avail;
  logic [N-1:0][PHYS_REG_IDX_BITS-1:0] inputs_retiring;
  logic [NUM_SCALAR_BITS-1:0]          num_retiring_valid;
  logic [PTR_BITS:0]                   head_out;
  logic                                restore_valid;
  logic [PTR_BITS:0]                   restore_head;
  logic [PTR_BITS:0]                   free_count;

  int checks = 0;
  int errors = 0;

  free_list dut (
    .clock              (clock),
    .reset              (reset),
    .num_allocating     (num_allocating),
    .allocated_regs     (allocated_regs),
    .num_avail          (num_avail),
    .inputs_retiring    (inputs_retiring),
    .num_retiring_valid (num_retiring_valid),
    .head_out           (head_out),
    .restore_valid      (restore_valid),
    .restore_head       (restore_head),
    .free_count         (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unbounded head/tail counters over a DEPTH-slot ring.
  int  mem_m [DEPTH];
  int  head_m;
  int  tail_m;
  bit  model_ready = 0;

  always @(posedge clock) begin
    int cnt, avail, alloc, rh;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = ARCH_REGS + i;
      head_m = 0;
      tail_m = DEPTH;
      model_ready = 1;
    end else if (model_ready) begin
      cnt   = tail_m - head_m;
      avail = (cnt < N) ? cnt : N;
      alloc = (int'(num_allocating) < avail) ? int'(num_allocating) : avail;
      for (int i = 0; i < int'(num_retiring_valid); i++)
        mem_m[(tail_m + i) % DEPTH] = int'(inputs_retiring[i]);
      if (restore_valid) begin
        // The checkpoint is the unique head at most 2*DEPTH-1 behind tail.
        rh = (((tail_m - int'(restore_head)) % (2 * DEPTH)) + 2 * DEPTH) % (2 * DEPTH);
        head_m = tail_m - rh;
      end else begin
        head_m = head_m + alloc;
      end
      tail_m = tail_m + int'(num_retiring_valid);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    int cnt, avail;
    if (model_ready) begin
      cnt   = tail_m - head_m;
      avail = (cnt < N) ? cnt : N;
      check("model_free_count", int'(free_count), cnt);
      check("model_head_out", int'(head_out), head_m % (2 * DEPTH));
      check("model_num_avail", int'(num_avail), avail);
      for (int i = 0; i < avail; i++)
        check($sformatf("model_lane%0d", i), int'(allocated_regs[i]),
              mem_m[(head_m + i) % DEPTH]);
    end
  end

  task automatic step_full(input int na, input int nr, input int t0, input int t1,
                           input int t2, input bit rv, input int rh, input bit rst);
    num_allocating     = NUM_SCALAR_BITS'(na);
    num_retiring_valid = NUM_SCALAR_BITS'(nr);
    inputs_retiring[0] = PHYS_REG_IDX_BITS'(t0);
    inputs_retiring[1] = PHYS_REG_IDX_BITS'(t1);
    inputs_retiring[2] = PHYS_REG_IDX_BITS'(t2);
    restore_valid      = rv;
    restore_head       = (PTR_BITS + 1)'(rh);
    reset              = rst;
    @(posedge clock);
    @(negedge clock);
    #1;
    num_allocating     = '0;
    num_retiring_valid = '0;
    inputs_retiring    = '0;
    restore_valid      = 1'b0;
    restore_head       = '0;
    reset              = 1'b0;
  endtask

  task automatic step(input int na, input int nr, input int t0, input int t1, input int t2);
    step_full(na, nr, t0, t1, t2, 1'b0, 0, 1'b0);
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    int ckpt;
    reset = 1'b1;
    num_allocating = '0;
    num_retiring_valid = '0;
    inputs_retiring = '0;
    restore_valid = 1'b0;
    restore_head = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;

    check("reset_free_count", int'(free_count), 32);
    check("reset_num_avail", int'(num_avail), 3);
    check("reset_head_out", int'(head_out), 0);
    check("reset_lane0", int'(allocated_regs[0]), 32);
    check("reset_lane1", int'(allocated_regs[1]), 33);
    check("reset_lane2", int'(allocated_regs[2]), 34);

    // Allocate 3 from a full list.
    step(3, 0, 0, 0, 0);
    check("alloc3_free_count", int'(free_count), 29);
    check("alloc3_head_out", int'(head_out), 3);
    check("alloc3_lane0", int'(allocated_regs[0]), 35);

    // Retire 5,6,7 into slots 0..2; tail wraps back to full.
    step(0, 3, 5, 6, 7);
    check("refill_free_count", int'(free_count), 32);

    // Allocate 2, then allocate 2 while retiring 8 into slot 3.
    step(2, 0, 0, 0, 0);
    step(2, 1, 8, 0, 0);
    check("simul_free_count", int'(free_count), 29);
    check("simul_head_out", int'(head_out), 7);
    check("simul_lane0", int'(allocated_regs[0]), 39);

    // Checkpoint, allocate 6, restore with one retire (tag 9 to slot 4).
    ckpt = int'(head_out);
    step(3, 0, 0, 0, 0);
    step(3, 0, 0, 0, 0);
    check("pre_restore_count", int'(free_count), 23);
    step_full(3, 1, 9, 0, 0, 1'b1, ckpt, 1'b0);
    check("restore_head_out", int'(head_out), 7);
    check("restore_free_count", int'(free_count), 30);
    check("restore_lane0", int'(allocated_regs[0]), 39);

    // Drain to head 31: lanes wrap to slots 31, 0, 1.
    for (int i = 0; i < 8; i++) step(3, 0, 0, 0, 0);
    check("wrap_head_out", int'(head_out), 31);
    check("wrap_lane0", int'(allocated_regs[0]), 63);
    check("wrap_lane1", int'(allocated_regs[1]), 5);
    check("wrap_lane2", int'(allocated_regs[2]), 6);

    // Head reaches slot 0: retired tags 5,6,7 come back out.
    step(1, 0, 0, 0, 0);
    check("reuse_head_out", int'(head_out), 32);
    check("reuse_lane0", int'(allocated_regs[0]), 5);
    check("reuse_lane1", int'(allocated_regs[1]), 6);
    check("reuse_lane2", int'(allocated_regs[2]), 7);

    // Partial availability, then empty.
    step(3, 0, 0, 0, 0);
    check("partial_num_avail", int'(num_avail), 2);
    check("partial_lane0", int'(allocated_regs[0]), 8);
    check("partial_lane1", int'(allocated_regs[1]), 9);
    step(2, 0, 0, 0, 0);
    check("empty_num_avail", int'(num_avail), 0);
    check("empty_free_count", int'(free_count), 0);

    // Retire 40 into an empty list; visible only on the following cycle.
    step(0, 1, 40, 0, 0);
    check("refill1_num_avail", int'(num_avail), 1);
    check("refill1_lane0", int'(allocated_regs[0]), 40);

    // Mixed traffic checked by the model alone.
    step(1, 3, 41, 42, 43);
    step(2, 3, 44, 45, 46);
    step(3, 2, 47, 48, 0);
    step(0, 3, 49, 50, 51);
    step(3, 1, 52, 0, 0);
    check("mixed_free_count", int'(free_count), 4);

    // Reset overrides a simultaneous restore, allocate and retire.
    step_full(1, 1, 20, 0, 0, 1'b1, 4, 1'b1);
    check("rst_free_count", int'(free_count), 32);
    check("rst_head_out", int'(head_out), 0);
    check("rst_lane0", int'(allocated_regs[0]), 32);
    check("rst_num_avail", int'(num_avail), 3);

    step(3, 0, 0, 0, 0);
    check("post_rst_head_out", int'(head_out), 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
